// File: rtl/skid_fifo_pipe.sv
// Valid/ready elastic buffer: DEPTH-entry first-word-fall-through FIFO with a
// selectable registered or combinational ready path, synchronous flush and occupancy count.
module skid_fifo_pipe #(
  parameter int unsigned L      = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OPTREG = 1,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  output logic          ready_f,
  input  logic          valid_f,
  input  logic [L-1:0]  data_f,
  input  logic          ready_b,
  output logic          valid_b,
  output logic [L-1:0]  data_b,
  output logic [CW-1:0] count
);

  logic [L-1:0]  mem_q [DEPTH];
  logic [L-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          full_q, full_d;
  logic          push, pop;

  // With OPTREG=0 a full buffer still accepts when the head leaves on the same edge.
  assign ready_f = (OPTREG != 0) ? ~full_q : (~full_q | ready_b);

  assign push    = valid_f & ready_f;
  assign pop     = valid_q & ready_b;
  assign valid_b = valid_q;
  assign data_b  = mem_q[rp_q];
  assign count   = count_q;

  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wp_q] = data_f;
        wp_d        = wp_q + AW'(1);
      end
      if (pop) begin
        rp_d = rp_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    valid_d = (count_d != '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: tb/tb_skid_fifo_pipe.sv
// Drives one OPTREG=1 and one OPTREG=0 instance with shared stimulus and checks each
// against its own queue scoreboard every cycle.
module tb_skid_fifo_pipe;

  localparam int unsigned L     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          valid_f;
  logic [L-1:0]  data_f;
  logic          ready_b;
  logic          ready_f1, valid_b1, ready_f0, valid_b0;
  logic [L-1:0]  data_b1, data_b0;
  logic [CW-1:0] count1, count0;

  int total = 0;
  int bad   = 0;
  logic [L-1:0] q1[$];
  logic [L-1:0] q0[$];

  always #5 clk = ~clk;

  skid_fifo_pipe #(.L(L), .DEPTH(DEPTH), .OPTREG(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .ready_f(ready_f1), .valid_f(valid_f),
    .data_f(data_f), .ready_b(ready_b), .valid_b(valid_b1), .data_b(data_b1), .count(count1)
  );

  skid_fifo_pipe #(.L(L), .DEPTH(DEPTH), .OPTREG(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .ready_f(ready_f0), .valid_f(valid_f),
    .data_f(data_f), .ready_b(ready_b), .valid_b(valid_b0), .data_b(data_b0), .count(count0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check_eq("rst_rf1", 32'(ready_f1), 32'd1);
    check_eq("rst_vb1", 32'(valid_b1), 32'd0);
    check_eq("rst_cnt1", 32'(count1), 32'd0);
    check_eq("rst_db1", 32'(data_b1), 32'd0);
    check_eq("rst_rf0", 32'(ready_f0), 32'd1);
    check_eq("rst_vb0", 32'(valid_b0), 32'd0);
    check_eq("rst_cnt0", 32'(count0), 32'd0);
    check_eq("rst_db0", 32'(data_b0), 32'd0);
  endtask

  // Called at posedge+1 with inputs set; checks at negedge, updates models, returns after next edge.
  task automatic cycle();
    logic exp_rf1, exp_rf0, push1, pop1, push0, pop0;
    @(negedge clk);
    exp_rf1 = (q1.size() != DEPTH);
    exp_rf0 = (q0.size() != DEPTH) || ready_b;
    check_eq("ready_f1", 32'(ready_f1), 32'(exp_rf1));
    check_eq("valid_b1", 32'(valid_b1), 32'(q1.size() != 0));
    check_eq("count1", 32'(count1), 32'(q1.size()));
    if (q1.size() != 0) check_eq("data_b1", 32'(data_b1), 32'(q1[0]));
    check_eq("ready_f0", 32'(ready_f0), 32'(exp_rf0));
    check_eq("valid_b0", 32'(valid_b0), 32'(q0.size() != 0));
    check_eq("count0", 32'(count0), 32'(q0.size()));
    if (q0.size() != 0) check_eq("data_b0", 32'(data_b0), 32'(q0[0]));
    push1 = valid_f && exp_rf1;
    pop1  = ready_b && (q1.size() != 0);
    push0 = valid_f && exp_rf0;
    pop0  = ready_b && (q0.size() != 0);
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (pop1) void'(q1.pop_front());
      if (push1) q1.push_back(data_f);
      if (pop0) void'(q0.pop_front());
      if (push0) q0.push_back(data_f);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [L-1:0] d, input logic rb, input logic fl);
    valid_f = v;
    data_f  = d;
    ready_b = rb;
    flush   = fl;
    cycle();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; valid_f = 1'b0; data_f = '0; ready_b = 1'b0;
    #2;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming: one word per cycle, occupancy settles at one.
    for (int i = 1; i <= 16; i++) drive(1'b1, L'(i), 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill with ready_b low, then single-cycle pop; OPTREG=0 instance also pushes 0xA4.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + L'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'hA4, 1'b0, 1'b0);
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Full pass-through and wrap over 3*DEPTH words.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hB0 + L'(i), 1'b0, 1'b0);
    for (int i = 4; i < 4 + 3 * DEPTH; i++) drive(1'b1, 8'hB0 + L'(i), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with an offered word and a ready sink; the offered word must vanish.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hC0 + L'(i), 1'b0, 1'b0);
    drive(1'b1, 8'hC3, 1'b1, 1'b1);
    drive(1'b1, 8'hC5, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-burst, away from any clock edge.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hD0 + L'(i), 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    check_reset_state();
    q1.delete();
    q0.delete();
    #1;
    rst = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 9) < 6), L'($urandom), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
